ofm_writer: RTL

OFM_WRITER -- requirements
Module: ofm_writer

---
 rtl/cnn_acc_pkg.sv | 17 +
 rtl/ofm_word_fifo.sv | 62 ++++++
 rtl/ofm_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_acc_pkg.sv
// Shared constants and types for the CNN accelerator output path.
package cnn_acc_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } ofm_state_t;

endpackage

// File: rtl/ofm_word_fifo.sv
// Synchronous word FIFO between the byte packer and the output memory port.
// DEPTH must be a power of two (>= 2); a pop frees room for a same-cycle push.
module ofm_word_fifo
    import cnn_acc_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofm_writer.sv
// Output feature-map writer: requantizes two accelerator output ports to
// bytes, packs them little-endian into 32-bit words and streams the words
// to output memory through ofm_word_fifo.
// Build option: define OFM_WRITER_RELU_EN to clamp negative values to zero
// before rounding.
module ofm_writer
    import cnn_acc_pkg::*;
#(
    parameter int DATA_W     = 25,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_conv,
    input  logic [4:0]        cfg_shift,
    input  logic [DATA_W-1:0] ofm_port0,
    input  logic [DATA_W-1:0] ofm_port1,
    input  logic              ofm_port0_v,
    input  logic              ofm_port1_v,
    input  logic              end_conv,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              done,
    output logic              overflow
);

    localparam logic signed [DATA_W:0] Q_MAX = (DATA_W+1)'(SAT_MAX);
    localparam logic signed [DATA_W:0] Q_MIN = (DATA_W+1)'(SAT_MIN);

    ofm_state_t        state;
    logic [4:0]        shift_q;
    logic              q0_v, q1_v;
    logic [BYTE_W-1:0] q0_b, q1_b;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] acc;
    logic              pend_v;
    logic [WORD_W-1:0] pend_w;
    logic [WORD_W-1:0] nxt_acc;
    logic [1:0]        nxt_cnt;
    logic              word_done;
    logic [WORD_W-1:0] done_word;
    logic              fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic              start_ok, accept, pop, q_empty, flush_partial;

    // ReLU (optional), round half up, arithmetic shift, saturate to int8.
    function automatic logic [BYTE_W-1:0] quantize(
        input logic [DATA_W-1:0] v,
        input logic [4:0]        s
    );
        logic signed [DATA_W:0] x;
        logic signed [DATA_W:0] rnd;
        logic [BYTE_W-1:0]      res;
        x = {v[DATA_W-1], v};
`ifdef OFM_WRITER_RELU_EN
        if (x[DATA_W]) begin
            x = '0;
        end
`endif
        rnd = '0;
        if (s != 5'd0) begin
            rnd = (DATA_W+1)'(1) << (s - 5'd1);
        end
        x = x + rnd;
        x = x >>> s;
        if (x > Q_MAX) begin
            res = BYTE_W'(SAT_MAX);
        end else if (x < Q_MIN) begin
            res = BYTE_W'(SAT_MIN);
        end else begin
            res = x[BYTE_W-1:0];
        end
        return res;
    endfunction

    assign start_ok      = start_conv && (state == ST_IDLE || state == ST_DONE);
    assign accept        = (state == ST_RUN);
    assign q_empty       = !q0_v && !q1_v;
    assign flush_partial = (state == ST_FLUSH) && q_empty && (byte_cnt != 2'd0);
    assign mem_wr_en     = !fifo_empty;
    assign mem_wr_data   = fifo_empty ? '0 : fifo_head;
    assign pop           = mem_wr_en && mem_wr_ready;

    // Quantize stage: one registered byte per port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0_v <= 1'b0;
            q1_v <= 1'b0;
            q0_b <= '0;
            q1_b <= '0;
        end else begin
            q0_v <= ofm_port0_v && accept;
            q1_v <= ofm_port1_v && accept;
            q0_b <= quantize(ofm_port0, shift_q);
            q1_b <= quantize(ofm_port1, shift_q);
        end
    end

    // Byte placement: port0 before port1; at most one word completes per cycle.
    always_comb begin
        nxt_acc   = acc;
        nxt_cnt   = byte_cnt;
        word_done = 1'b0;
        done_word = '0;
        if (q0_v) begin
            nxt_acc[{nxt_cnt, 3'b000} +: BYTE_W] = q0_b;
            if (nxt_cnt == 2'd3) begin
                word_done = 1'b1;
                done_word = nxt_acc;
                nxt_acc   = '0;
            end
            nxt_cnt = nxt_cnt + 2'd1;
        end
        if (q1_v) begin
            nxt_acc[{nxt_cnt, 3'b000} +: BYTE_W] = q1_b;
            if (nxt_cnt == 2'd3) begin
                word_done = 1'b1;
                done_word = nxt_acc;
                nxt_acc   = '0;
            end
            nxt_cnt = nxt_cnt + 2'd1;
        end
    end

    // Packer state and the one-cycle pending word feeding the FIFO.
    // acc is zeroed whenever a word leaves, so a flushed partial is already padded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            byte_cnt <= '0;
            pend_v   <= 1'b0;
            pend_w   <= '0;
        end else if (start_ok) begin
            acc      <= '0;
            byte_cnt <= '0;
            pend_v   <= 1'b0;
        end else begin
            pend_v <= word_done || flush_partial;
            if (word_done) begin
                pend_w <= done_word;
            end else if (flush_partial) begin
                pend_w <= acc;
            end
            if (flush_partial) begin
                acc      <= '0;
                byte_cnt <= '0;
            end else begin
                acc      <= nxt_acc;
                byte_cnt <= nxt_cnt;
            end
        end
    end

    ofm_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend_v),
        .push_data (pend_w),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Layer sequencing, write address, done pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            mem_wr_addr <= '0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                mem_wr_addr <= mem_wr_addr + 1'b1;
            end
            if (pend_v && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (start_ok) begin
                shift_q     <= cfg_shift;
                overflow    <= 1'b0;
                mem_wr_addr <= '0;
                state       <= ST_RUN;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_IDLE;
                    ST_RUN:   if (end_conv) state <= ST_FLUSH;
                    ST_FLUSH: if (q_empty && byte_cnt == 2'd0 && !pend_v) state <= ST_DRAIN;
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    ST_DONE:  state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
